// File: rtl/mobo_bus_arbiter.sv
// Round-robin arbiter that shares the motherboard bus between the cpu (m0)
// and the VGA reader (m1). One transaction at a time, a ready handshake to the
// target, and a timeout so a dead target cannot stall a requester forever.
module mobo_bus_arbiter #(
    parameter int unsigned word_width     = 32,
    parameter int unsigned timeout_cycles = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [word_width-1:0] m0_addr,
    input  logic [word_width-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_done,
    output logic                  m0_err,
    output logic [word_width-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [word_width-1:0] m1_addr,
    input  logic [word_width-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic                  m1_err,
    output logic [word_width-1:0] m1_rdata,

    output logic                  bus_valid,
    output logic                  bus_we,
    output logic [word_width-1:0] bus_addr,
    output logic [word_width-1:0] bus_wdata,
    input  logic                  bus_ready,
    input  logic [word_width-1:0] bus_rdata
);

    localparam int unsigned cnt_width = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [cnt_width-1:0] cnt_last = cnt_width'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state;
    logic                 owner;        // 0 = m0, 1 = m1
    logic                 last_served;  // 0 = m0, 1 = m1
    logic [cnt_width-1:0] cnt;
    logic                 pick_m1;
    logic                 timed_out;

    // Winner of an IDLE decision: m1 only if it requests and m0 does not, or
    // both request and m0 was served last.
    assign pick_m1   = m1_req && (!m0_req || !last_served);
    assign timed_out = (timeout_cycles != 0) && (cnt == cnt_last);

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            cnt         <= '0;
            m0_gnt      <= 1'b0;
            m0_done     <= 1'b0;
            m0_err      <= 1'b0;
            m0_rdata    <= '0;
            m1_gnt      <= 1'b0;
            m1_done     <= 1'b0;
            m1_err      <= 1'b0;
            m1_rdata    <= '0;
            bus_valid   <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        owner     <= pick_m1;
                        m0_gnt    <= !pick_m1;
                        m1_gnt    <= pick_m1;
                        bus_valid <= 1'b1;
                        bus_we    <= pick_m1 ? m1_we    : m0_we;
                        bus_addr  <= pick_m1 ? m1_addr  : m0_addr;
                        bus_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                        cnt       <= '0;
                        state     <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (bus_ready) begin
                        // Ready beats a simultaneous terminal count.
                        if (owner) begin
                            m1_done <= 1'b1;
                            m1_err  <= 1'b0;
                            if (!bus_we) m1_rdata <= bus_rdata;
                        end else begin
                            m0_done <= 1'b1;
                            m0_err  <= 1'b0;
                            if (!bus_we) m0_rdata <= bus_rdata;
                        end
                        bus_valid <= 1'b0;
                        state     <= ST_RESP;
                    end else if (timed_out) begin
                        if (owner) begin
                            m1_done <= 1'b1;
                            m1_err  <= 1'b1;
                        end else begin
                            m0_done <= 1'b1;
                            m0_err  <= 1'b1;
                        end
                        bus_valid <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + cnt_width'(1);
                    end
                end

                ST_RESP: begin
                    m0_done     <= 1'b0;
                    m1_done     <= 1'b0;
                    m0_gnt      <= 1'b0;
                    m1_gnt      <= 1'b0;
                    last_served <= owner;
                    state       <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mobo_bus_arbiter.sv
// Randomized bench for mobo_bus_arbiter, checked every cycle against a
// transaction-level reference model of the arbitration rules.
module tb_mobo_bus_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 16;
    localparam int unsigned N_CYCLES = 3600;

    logic         clk;
    logic         rst;
    logic         req   [2];
    logic         we    [2];
    logic [W-1:0] addr  [2];
    logic [W-1:0] wdata [2];
    logic         ready;
    logic [W-1:0] rdata_in;

    logic         m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [W-1:0] m0_rdata, m1_rdata;
    logic         bus_valid, bus_we;
    logic [W-1:0] bus_addr, bus_wdata;

    mobo_bus_arbiter #(.word_width(W), .timeout_cycles(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (req[0]),
        .m0_we     (we[0]),
        .m0_addr   (addr[0]),
        .m0_wdata  (wdata[0]),
        .m0_gnt    (m0_gnt),
        .m0_done   (m0_done),
        .m0_err    (m0_err),
        .m0_rdata  (m0_rdata),
        .m1_req    (req[1]),
        .m1_we     (we[1]),
        .m1_addr   (addr[1]),
        .m1_wdata  (wdata[1]),
        .m1_gnt    (m1_gnt),
        .m1_done   (m1_done),
        .m1_err    (m1_err),
        .m1_rdata  (m1_rdata),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (ready),
        .bus_rdata (rdata_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: who holds the bus, how long it has waited, and
    // which master is in its completion-pulse cycle.
    bit           in_flight;
    int           cur;
    int           waits;
    int           resp_o;
    int           last;
    logic         e_gnt   [2];
    logic         e_done  [2];
    logic         e_err   [2];
    logic [W-1:0] e_rdata [2];
    logic         e_valid, e_we;
    logic [W-1:0] e_addr, e_wdata;

    bit           wait_done [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_flight = 1'b0;
        cur = 0; waits = 0; resp_o = -1; last = 1;
        for (int i = 0; i < 2; i++) begin
            e_gnt[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0; e_rdata[i] = '0;
        end
        e_valid = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    endtask

    task automatic model_complete(input bit timeout);
        e_done[cur] = 1'b1;
        e_err[cur]  = timeout;
        if (!timeout && !e_we) e_rdata[cur] = rdata_in;
        e_valid   = 1'b0;
        resp_o    = cur;
        in_flight = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (resp_o >= 0) begin
            e_done[resp_o] = 1'b0;
            e_gnt[resp_o]  = 1'b0;
            last   = resp_o;
            resp_o = -1;
        end else if (in_flight) begin
            if (ready) model_complete(1'b0);
            else begin
                waits++;
                if (TO != 0 && waits == int'(TO)) model_complete(1'b1);
            end
        end else if (req[0] || req[1]) begin
            if (req[0] && req[1]) cur = 1 - last;
            else cur = req[1] ? 1 : 0;
            in_flight  = 1'b1;
            waits      = 0;
            e_gnt[cur] = 1'b1;
            e_valid    = 1'b1;
            e_we       = we[cur];
            e_addr     = addr[cur];
            e_wdata    = wdata[cur];
        end
    endtask

    task automatic new_txn(input int i);
        req[i]   = 1'b1;
        we[i]    = 1'($urandom_range(0, 1));
        addr[i]  = $urandom;
        wdata[i] = $urandom;
    endtask

    task automatic compare_all();
        check("m0_gnt",    32'(m0_gnt),    32'(e_gnt[0]));
        check("m1_gnt",    32'(m1_gnt),    32'(e_gnt[1]));
        check("m0_done",   32'(m0_done),   32'(e_done[0]));
        check("m1_done",   32'(m1_done),   32'(e_done[1]));
        check("m0_err",    32'(m0_err),    32'(e_err[0]));
        check("m1_err",    32'(m1_err),    32'(e_err[1]));
        check("m0_rdata",  m0_rdata,       e_rdata[0]);
        check("m1_rdata",  m1_rdata,       e_rdata[1]);
        check("bus_valid", 32'(bus_valid), 32'(e_valid));
        check("bus_we",    32'(bus_we),    32'(e_we));
        check("bus_addr",  bus_addr,       e_addr);
        check("bus_wdata", bus_wdata,      e_wdata);
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; rdata_in = '0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wait_done[i] = 1'b0;
        end
        model_reset();
        @(posedge clk);
        model_step();
        @(negedge clk);

        for (cyc = 0; cyc < int'(N_CYCLES); cyc++) begin
            compare_all();

            // Reset: held at start, then occasional pulses in the last phase.
            rst = (cyc < 2) || (cyc >= 3000 && $urandom_range(0, 40) == 0);

            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    req[i] = 1'b0; wait_done[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (e_done[i]) begin
                        wait_done[i] = 1'b0;
                        if ($urandom_range(0, 1) == 1) new_txn(i);
                        else req[i] = 1'b0;
                    end else if (!req[i] && !wait_done[i]) begin
                        if (cyc < 400 || $urandom_range(0, 3) == 0) new_txn(i);
                    end else if (req[i] && e_gnt[i] && $urandom_range(0, 15) == 0) begin
                        req[i] = 1'b0;
                        wait_done[i] = 1'b1;
                    end
                end
            end

            // Target behaviour: random, dead, or ready exactly at terminal count.
            rdata_in = $urandom;
            if (cyc < 1500)      ready = ($urandom_range(0, 9) < 4);
            else if (cyc < 2200) ready = 1'b0;
            else if (cyc < 3000) ready = in_flight && (waits == int'(TO) - 1);
            else                 ready = ($urandom_range(0, 9) < 2);

            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
